// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared register-file widths and the loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        DRAIN     = 2'd2,
        DONE_ZERO = 2'd3
    } rf_loader_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_loader_if
//  Description : Valid/ready word stream feeding the register-file loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/rf_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rf_loader
//  Description : Boot/debug loader that owns the register-file write port
//                while streaming words into consecutive registers, and
//                passes CPU writeback straight through while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_loader
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W:0]   count,
    rf_loader_if.slave        stream,
    input  logic [ADDR_W-1:0] cpu_writereg,
    input  logic [DATA_W-1:0] cpu_writedata,
    input  logic              cpu_write,
    output logic [ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0] writedata,
    output logic              write,
    output logic              busy,
    output logic              done,
    output logic              cpu_conflict
);

    localparam logic [ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE = 1;

    rf_loader_state_t  state_q;
    rf_loader_state_t  state_d;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] wr_q;
    logic [DATA_W-1:0] wd_q;
    logic              we_q;

    logic              in_ready;
    logic              accept;
    logic              load_go;
    logic              block_cpu;

    // A non-empty load request is only honoured from IDLE; count==0 takes the DONE_ZERO path.
    assign load_go         = (state_q == IDLE) && start && (count != '0);
    assign accept          = in_ready && stream.in_valid;
    assign stream.in_ready = in_ready;

    // Next-state selection and per-state control outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        block_cpu = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? DONE_ZERO : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (stream.in_valid && (remaining == REM_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            DONE_ZERO: begin
                done      = 1'b1;
                block_cpu = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Index/remaining counters and the one-deep write staging register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            remaining <= '0;
            wr_q      <= '0;
            wd_q      <= '0;
            we_q      <= 1'b0;
        end else begin
            we_q <= accept;
            if (load_go) begin
                idx       <= first_reg;
                remaining <= count;
            end else if (accept) begin
                wr_q      <= idx;
                wd_q      <= stream.in_data;
                idx       <= idx + IDX_ONE;      // 31 wraps naturally to 0
                remaining <= remaining - REM_ONE;
            end
        end
    end

    // Sticky flag for CPU writes dropped while the loader owned the port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_conflict <= 1'b0;
        end else if (load_go) begin
            cpu_conflict <= 1'b0;
        end else if (busy && cpu_write) begin
            cpu_conflict <= 1'b1;
        end
    end

    // Write-port mux: loader staging while busy, CPU pass-through otherwise.
    always_comb begin
        if (busy) begin
            write     = we_q;
            writereg  = wr_q;
            writedata = wd_q;
        end else begin
            write     = cpu_write && !block_cpu;
            writereg  = cpu_writereg;
            writedata = cpu_writedata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_loader
//  Description : Self-checking bench for rf_loader with a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_loader;
    import mips_pkg::*;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_reg;
    logic [5:0]  count;
    logic [4:0]  cpu_writereg;
    logic [31:0] cpu_writedata;
    logic        cpu_write;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        write;
    logic        busy;
    logic        done;
    logic        cpu_conflict;

    int          pass_cnt    = 0;
    int          total_cnt   = 0;
    int          writes_seen = 0;
    int          done_seen   = 0;
    int          w0;
    int          d0;

    wr_t         sb_q[$];
    wr_t         mon_e;
    logic [31:0] tx_q[$];
    logic [31:0] rf_model [NUM_REGS];

    always #5 clk = ~clk;

    rf_loader_if #(.DATA_W(DATA_W)) stream_if ();

    rf_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .first_reg     (first_reg),
        .count         (count),
        .stream        (stream_if),
        .cpu_writereg  (cpu_writereg),
        .cpu_writedata (cpu_writedata),
        .cpu_write     (cpu_write),
        .writereg      (writereg),
        .writedata     (writedata),
        .write         (write),
        .busy          (busy),
        .done          (done),
        .cpu_conflict  (cpu_conflict)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Register file stand-in: commits whatever the port presents.
    always @(posedge clk) begin
        if (write === 1'b1) rf_model[writereg] <= writedata;
    end

    // Scoreboard consumer: every loader write must match the oldest accepted word.
    always @(negedge clk) begin
        if (write === 1'b1 && busy === 1'b1) begin
            writes_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_write", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("write_reg", writereg, mon_e.r);
                check("write_data", writedata, mon_e.d);
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            if (busy === 1'b1) check("done_with_last_write", {write, sb_q.size() == 0}, 2'b11);
            else               check("done_zero_no_write", write, 1'b0);
        end
    end

    task automatic start_load(input logic [4:0] fr, input logic [5:0] cnt);
        start     = 1'b1;
        first_reg = fr;
        count     = cnt;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Offers n words from tx_q; each accepted word is pushed as an expected write.
    task automatic send_words(input logic [4:0] base, input bit gaps, input int n);
        int  sent = 0;
        int  cyc  = 0;
        wr_t e;
        while (sent < n && cyc < 200) begin
            stream_if.in_valid = !(gaps && (cyc % 2 == 1));
            stream_if.in_data  = tx_q[sent];
            @(negedge clk);
            if (stream_if.in_valid === 1'b1 && stream_if.in_ready === 1'b1) begin
                e.r = base + 5'(sent);
                e.d = tx_q[sent];
                sb_q.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        stream_if.in_valid = 1'b0;
        check("stream_accepted", sent, n);
        tx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n              = 1'b0;
        start              = 1'b0;
        first_reg          = '0;
        count              = '0;
        cpu_write          = 1'b0;
        cpu_writereg       = '0;
        cpu_writedata      = '0;
        stream_if.in_valid = 1'b0;
        stream_if.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", stream_if.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_conflict", cpu_conflict, 0);
        check("rst_write", write, 0);
        check("rst_writereg", writereg, 0);
        check("rst_writedata", writedata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU pass-through in IDLE is combinational.
        cpu_write = 1'b1; cpu_writereg = 5'd2; cpu_writedata = 32'd45;
        #1;
        check("pt_write", write, 1);
        check("pt_reg", writereg, 2);
        check("pt_data", writedata, 45);
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_writereg = '0; cpu_writedata = '0;
        check("pt_rf2", rf_model[2], 45);

        // in_valid while idle is not consumed.
        w0 = writes_seen;
        stream_if.in_valid = 1'b1; stream_if.in_data = 32'hBAD;
        #1;
        check("idle_in_ready", stream_if.in_ready, 0);
        @(posedge clk); #1;
        stream_if.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_write", writes_seen - w0, 0);

        // Basic two-word load.
        w0 = writes_seen; d0 = done_seen;
        tx_q = '{32'hA, 32'h6};
        start_load(5'd16, 6'd2);
        check("load_in_ready", stream_if.in_ready, 1);
        check("load_busy", busy, 1);
        send_words(5'd16, 1'b0, 2);
        stream_if.in_valid = 1'b1; stream_if.in_data = 32'hEEE;
        #1;
        check("drain_done", done, 1);
        check("drain_in_ready", stream_if.in_ready, 0);
        check("drain_write", write, 1);
        check("drain_reg", writereg, 17);
        @(posedge clk); #1;
        stream_if.in_valid = 1'b0;
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        @(posedge clk); #1;
        check("basic_writes", writes_seen - w0, 2);
        check("basic_dones", done_seen - d0, 1);
        check("basic_rf16", rf_model[16], 32'hA);
        check("basic_rf17", rf_model[17], 32'h6);

        // Wrap-around from register 30.
        w0 = writes_seen; d0 = done_seen;
        tx_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        start_load(5'd30, 6'd4);
        send_words(5'd30, 1'b0, 4);
        repeat (2) @(posedge clk);
        #1;
        check("wrap_writes", writes_seen - w0, 4);
        check("wrap_dones", done_seen - d0, 1);
        check("wrap_rf30", rf_model[30], 1);
        check("wrap_rf31", rf_model[31], 2);
        check("wrap_rf0", rf_model[0], 3);
        check("wrap_rf1", rf_model[1], 4);

        // Full file with every-other-cycle stalls.
        w0 = writes_seen; d0 = done_seen;
        for (int i = 0; i < 32; i++) tx_q.push_back(32'(i));
        start_load(5'd0, 6'd32);
        send_words(5'd0, 1'b1, 32);
        repeat (2) @(posedge clk);
        #1;
        check("full_writes", writes_seen - w0, 32);
        check("full_dones", done_seen - d0, 1);
        check("full_rf12", rf_model[12], 12);
        check("full_rf31", rf_model[31], 31);

        // Zero-count load: done pulse, write held low even with CPU traffic.
        w0 = writes_seen; d0 = done_seen;
        start_load(5'd3, 6'd0);
        cpu_write = 1'b1; cpu_writereg = 5'd7; cpu_writedata = 32'h77;
        #1;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_write", write, 0);
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_writereg = '0; cpu_writedata = '0;
        check("zero_done_after", done, 0);
        check("zero_dones", done_seen - d0, 1);
        check("zero_writes", writes_seen - w0, 0);

        // Conflict: CPU write to rf[5] during a load is dropped and flagged.
        cpu_write = 1'b1; cpu_writereg = 5'd5; cpu_writedata = 32'h55;
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_writereg = '0; cpu_writedata = '0;
        tx_q = '{32'h100, 32'h101, 32'h102};
        start_load(5'd8, 6'd3);
        fork
            send_words(5'd8, 1'b1, 3);
            begin
                @(posedge clk); #2;
                cpu_write = 1'b1; cpu_writereg = 5'd5; cpu_writedata = 32'hDEAD;
                @(posedge clk); #1;
                cpu_write = 1'b0; cpu_writereg = '0; cpu_writedata = '0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("conf_rf5", rf_model[5], 32'h55);
        check("conf_flag", cpu_conflict, 1);
        check("conf_rf10", rf_model[10], 32'h102);
        repeat (3) @(posedge clk);
        #1;
        check("conf_sticky", cpu_conflict, 1);
        tx_q = '{32'h200};
        start_load(5'd20, 6'd1);
        check("conf_cleared", cpu_conflict, 0);
        send_words(5'd20, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        check("single_rf20", rf_model[20], 32'h200);

        // Reset after two of five words.
        w0 = writes_seen; d0 = done_seen;
        tx_q = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h304};
        start_load(5'd10, 6'd5);
        send_words(5'd10, 1'b0, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", stream_if.in_ready, 0);
        check("mid_rst_write", write, 0);
        check("mid_rst_writereg", writereg, 0);
        check("mid_rst_writedata", writedata, 0);
        check("mid_rst_done", done, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_writes", writes_seen - w0, 2);
        check("mid_rst_dones", done_seen - d0, 0);
        check("mid_rst_rf10", rf_model[10], 32'h300);
        check("mid_rst_rf11", rf_model[11], 32'h301);
        check("mid_rst_rf12", rf_model[12], 12);
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
